ec_decoder_core: RTL and testbench

Arithmetic decoder core for the AV1 entropy-decode path; it is the receive-side counterpart of the encoder's Q15 range-update/one-round-normalization stage. It consumes a compressed byte stream and multi-symbol inverse-CDF requests, and returns one decoded symbol per request. It keeps the 32-bit `dif` window, the 16-bit `rng` and the signed bit counter `cnt`. All arithmetic is bit-exact with the reference daala/AV1 decoder (`EC_PROB_SHIFT` = 6, `EC_MIN_PROB` = 4).

---
 rtl/ec_decoder_core.sv | 189 ++++++++++++++++++
 tb/tb_ec_decoder_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_decoder_core.sv
// AV1/daala multi-symbol arithmetic decoder core: Q15 inverse-CDF symbol search,
// one-shot renormalization and byte-wise window refill of the dif register.
module ec_decoder_core #(
   parameter int RANGE_WIDTH  = 16,
   parameter int WINDOW_WIDTH = 32,
   parameter int CNT_WIDTH    = 16,
   parameter int D_SIZE       = 5,
   parameter int MAX_SYMS     = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [7:0]                      in_byte,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_eos,
   input  logic                            sym_valid,
   output logic                            sym_ready,
   input  logic [$clog2(MAX_SYMS):0]       sym_nsyms,
   input  logic [MAX_SYMS*RANGE_WIDTH-1:0] sym_icdf,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(MAX_SYMS)-1:0]     out_symbol,
   output logic [RANGE_WIDTH-1:0]          out_rng
);

   localparam int SYM_W         = $clog2(MAX_SYMS);
   localparam int EC_PROB_SHIFT = 6;
   localparam int EC_MIN_PROB   = 4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REFILL = 3'd1;
   localparam logic [2:0] S_READY  = 3'd2;
   localparam logic [2:0] S_SEARCH = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]                      state;
   logic [WINDOW_WIDTH-1:0]         dif;
   logic [RANGE_WIDTH-1:0]          rng;
   logic signed [CNT_WIDTH-1:0]     cnt;
   logic [MAX_SYMS*RANGE_WIDTH-1:0] icdf;
   logic [SYM_W-1:0]                n;
   logic [SYM_W-1:0]                ret;
   logic [SYM_W-1:0]                sym;
   logic [SYM_W-1:0]                out_sym;
   logic [RANGE_WIDTH-1:0]          c;
   logic [RANGE_WIDTH:0]            u;
   logic [RANGE_WIDTH-1:0]          r_new;
   logic                            from_sym;

   logic [RANGE_WIDTH-1:0]          icdf_sel;
   logic [2*RANGE_WIDTH-1:0]        prod;
   logic [RANGE_WIDTH:0]            v;
   logic                            c_below;
   logic [WINDOW_WIDTH-1:0]         dif_sub;
   logic [RANGE_WIDTH-1:0]          r_next;
   logic [D_SIZE-1:0]               d;
   logic [RANGE_WIDTH-1:0]          rng_norm;
   logic [WINDOW_WIDTH-1:0]         dif_norm;
   logic signed [CNT_WIDTH-1:0]     cnt_norm;
   logic signed [CNT_WIDTH:0]       s;
   logic                            s_ok;
   logic                            refill_last;
   logic [WINDOW_WIDTH-1:0]         byte_shifted;

   // Bound on the current icdf entry; r is rng itself since rng is frozen during SEARCH.
   always_comb begin
      icdf_sel = icdf[ret*RANGE_WIDTH +: RANGE_WIDTH];
      prod     = ({{RANGE_WIDTH{1'b0}}, rng} >> 8)
               * ({{RANGE_WIDTH{1'b0}}, icdf_sel} >> EC_PROB_SHIFT);
      v        = (RANGE_WIDTH+1)'(prod >> 1)
               + (RANGE_WIDTH+1)'(EC_MIN_PROB) * (RANGE_WIDTH+1)'(n - ret);
      c_below  = ({1'b0, c} < v);
      dif_sub  = dif - (WINDOW_WIDTH'(v) << (WINDOW_WIDTH - RANGE_WIDTH));
      r_next   = RANGE_WIDTH'(u - v);
   end

   always_comb begin
      d = D_SIZE'(RANGE_WIDTH - 1);
      for (int i = 0; i < RANGE_WIDTH; i++) begin
         if (r_new[i]) begin
            d = D_SIZE'(RANGE_WIDTH - 1 - i);
         end
      end
      rng_norm = r_new << d;
      dif_norm = ((dif + WINDOW_WIDTH'(1)) << d) - WINDOW_WIDTH'(1);
      cnt_norm = cnt - signed'(CNT_WIDTH'(d));
   end

   // Refill bit position; a byte that drives s below zero also ends the refill.
   always_comb begin
      s            = signed'((CNT_WIDTH+1)'(WINDOW_WIDTH - 24)) - (CNT_WIDTH+1)'(cnt);
      s_ok         = ~s[CNT_WIDTH];
      refill_last  = (s < signed'((CNT_WIDTH+1)'(8)));
      byte_shifted = WINDOW_WIDTH'(in_byte) << s;
   end

   assign in_ready   = (state == S_REFILL) && s_ok;
   assign sym_ready  = (state == S_READY);
   assign out_valid  = (state == S_DONE);
   assign out_symbol = out_sym;
   assign out_rng    = rng;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         dif      <= {1'b0, {(WINDOW_WIDTH-1){1'b1}}};
         rng      <= RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
         cnt      <= CNT_WIDTH'(-15);
         icdf     <= '0;
         n        <= '0;
         ret      <= '0;
         sym      <= '0;
         out_sym  <= '0;
         c        <= '0;
         u        <= '0;
         r_new    <= '0;
         from_sym <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_REFILL;
                  from_sym <= 1'b0;
               end
            end
            S_READY: begin
               if (sym_valid) begin
                  icdf  <= sym_icdf;
                  n     <= SYM_W'(sym_nsyms - (SYM_W+1)'(1));
                  c     <= dif[WINDOW_WIDTH-1 -: RANGE_WIDTH];
                  ret   <= '0;
                  u     <= {1'b0, rng};
                  state <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (c_below) begin
                  u   <= v;
                  ret <= ret + SYM_W'(1);
               end else begin
                  r_new <= r_next;
                  dif   <= dif_sub;
                  sym   <= ret;
                  state <= S_NORM;
               end
            end
            S_NORM: begin
               rng <= rng_norm;
               dif <= dif_norm;
               cnt <= cnt_norm;
               if (cnt_norm < 0) begin
                  state    <= S_REFILL;
                  from_sym <= 1'b1;
               end else begin
                  state   <= S_DONE;
                  out_sym <= sym;
               end
            end
            S_REFILL: begin
               if (!s_ok || (in_valid && refill_last) || (!in_valid && in_eos)) begin
                  if (from_sym) begin
                     state   <= S_DONE;
                     out_sym <= sym;
                  end else begin
                     state <= S_READY;
                  end
               end
               if (s_ok && in_valid) begin
                  dif <= dif ^ byte_shifted;
                  cnt <= cnt + signed'(CNT_WIDTH'(8));
               end else if (s_ok && in_eos) begin
                  cnt <= CNT_WIDTH'(16384);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_READY;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ec_decoder_core.sv
// Directed self-checking bench for ec_decoder_core: table of decode vectors with
// hand-computed results plus sequences for end-of-stream, hold and mid-flight reset.
module tb_ec_decoder_core;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic         in_ready;
   logic         in_eos;
   logic         sym_valid;
   logic         sym_ready;
   logic [4:0]   sym_nsyms;
   logic [255:0] sym_icdf;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_symbol;
   logic [15:0]  out_rng;

   int tests_run    = 0;
   int tests_failed = 0;
   int excl_viol    = 0;

   typedef struct {
      logic [7:0]   b0, b1, b2;
      logic [4:0]   nsyms;
      logic [255:0] icdf;
      logic [3:0]   exp_sym;
      logic [15:0]  exp_rng;
      logic [31:0]  exp_dif;
      logic [15:0]  exp_cnt;
      int           exp_lat;
      int           exp_bytes;
   } vec_t;

   vec_t vecs[4];

   ec_decoder_core dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_byte    (in_byte),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_eos     (in_eos),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .sym_nsyms  (sym_nsyms),
      .sym_icdf   (sym_icdf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_symbol (out_symbol),
      .out_rng    (out_rng)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset && (int'(in_ready) + int'(sym_ready) + int'(out_valid)) > 1) begin
         excl_viol++;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_state"}, 32'(dut.state), 32'h0);
      checkOutput({tag, "_dif"}, dut.dif, 32'h7FFFFFFF);
      checkOutput({tag, "_cnt"}, 32'({dut.cnt}), 32'h0000FFF1);
      checkOutput({tag, "_rng"}, 32'(out_rng), 32'h8000);
      checkOutput({tag, "_handshake"}, {29'd0, in_ready, sym_ready, out_valid}, 32'h0);
      checkOutput({tag, "_symbol"}, 32'(out_symbol), 32'h0);
   endtask

   task automatic doReset(input bit check);
      reset     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      in_eos    = 1'b0;
      sym_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (check) checkResetState("reset");
      reset = 1'b1;
   endtask

   task automatic applyStimulusInit(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                    output int cycles, output int nbytes);
      logic [7:0] bq[3];
      bq[0] = b0; bq[1] = b1; bq[2] = b2;
      nbytes = 0;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      while (!sym_ready && cycles < 20) begin
         if (in_ready) begin
            in_valid = 1'b1;
            in_byte  = (nbytes < 3) ? bq[nbytes] : 8'hAA;
            nbytes++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      in_valid = 1'b0;
   endtask

   task automatic applyStimulusRequest(input logic [4:0] ns, input logic [255:0] icdf, input logic [7:0] fill,
                                       output int lat, output int nbytes);
      sym_valid = 1'b1;
      sym_nsyms = ns;
      sym_icdf  = icdf;
      @(negedge clk);
      sym_valid = 1'b0;
      lat    = 1;
      nbytes = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) begin
            in_valid = 1'b1;
            in_byte  = fill;
            nbytes++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
   endtask

   task automatic holdAndAck(input logic [3:0] es, input logic [15:0] er);
      int ok = 1;
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!(out_valid === 1'b1 && out_symbol === es && out_rng === er && sym_ready === 1'b0)) ok = 0;
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("hold_stable", 32'(ok), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("ack_to_ready", {30'd0, sym_ready, out_valid}, 32'h2);
   endtask

   task automatic runVector(input int idx);
      int cycles, nbytes, lat;
      logic [31:0] init_dif;
      vec_t t;
      t = vecs[idx];
      doReset(idx == 0);
      applyStimulusInit(t.b0, t.b1, t.b2, cycles, nbytes);
      init_dif = 32'h7FFFFFFF ^ (32'(t.b0) << 23) ^ (32'(t.b1) << 15) ^ (32'(t.b2) << 7);
      checkOutput("init_cycles", 32'(cycles), 32'd4);
      checkOutput("init_bytes", 32'(nbytes), 32'd3);
      checkOutput("init_dif", dut.dif, init_dif);
      applyStimulusRequest(t.nsyms, t.icdf, 8'h00, lat, nbytes);
      checkOutput("latency", 32'(lat), 32'(t.exp_lat));
      checkOutput("refill_bytes", 32'(nbytes), 32'(t.exp_bytes));
      checkOutput("symbol", 32'(out_symbol), 32'(t.exp_sym));
      checkOutput("out_rng", 32'(out_rng), 32'(t.exp_rng));
      checkOutput("dif", dut.dif, t.exp_dif);
      checkOutput("cnt", 32'({dut.cnt}), 32'(t.exp_cnt));
      holdAndAck(t.exp_sym, t.exp_rng);
   endtask

   initial begin
      logic [255:0] icdf16;
      int cycles, nbytes, w, ok;

      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_eos = 1'b0;
      sym_valid = 1'b0; sym_nsyms = 5'd0; sym_icdf = '0; out_ready = 1'b0;

      icdf16 = '0;
      for (int k = 0; k < 15; k++) begin
         icdf16[k*16 +: 16] = 16'h8000 - 16'(k + 1) * 16'h0800;
      end

      vecs[0] = '{8'h00, 8'h00, 8'h00, 5'd2, 256'h4000, 4'd0, 16'hFFF0, 32'hFFEFFFFF, 16'h0007, 3, 0};
      vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 5'd2, 256'h4000, 4'd1, 16'h8008, 32'h000000FF, 16'h0008, 4, 0};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 5'd2, 256'h7FC0, 4'd0, 16'hF000, 32'hEFFFFFFF, 16'h000F, 5, 2};
      vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 5'd16, icdf16, 4'd15, 16'h8040, 32'h000007FF, 16'h0005, 18, 0};

      for (int i = 0; i < 4; i++) begin
         runVector(i);
      end

      // End of stream during a post-symbol refill after three stall cycles.
      doReset(1'b0);
      applyStimulusInit(8'h00, 8'h00, 8'h00, cycles, nbytes);
      sym_valid = 1'b1;
      sym_nsyms = 5'd2;
      sym_icdf  = 256'h7FC0;
      @(negedge clk);
      sym_valid = 1'b0;
      w = 0;
      while (!in_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      checkOutput("eos_reach_refill", 32'(w), 32'd2);
      ok = 1;
      for (int i = 0; i < 3; i++) begin
         if (!(in_ready === 1'b1 && out_valid === 1'b0)) ok = 0;
         @(negedge clk);
      end
      checkOutput("eos_stall_in_ready", 32'(ok), 32'd1);
      checkOutput("eos_cnt_before", 32'({dut.cnt}), 32'h0000FFFF);
      in_eos = 1'b1;
      @(negedge clk);
      in_eos = 1'b0;
      checkOutput("eos_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("eos_cnt", 32'({dut.cnt}), 32'h00004000);
      checkOutput("eos_dif", dut.dif, 32'hEFFFFFFF);
      checkOutput("eos_rng", 32'(out_rng), 32'hF000);
      holdAndAck(4'd0, 16'hF000);

      // Reset asserted in the middle of a long symbol search.
      doReset(1'b0);
      applyStimulusInit(8'hFF, 8'hFF, 8'hFF, cycles, nbytes);
      sym_valid = 1'b1;
      sym_nsyms = 5'd16;
      sym_icdf  = icdf16;
      @(negedge clk);
      sym_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("mid_search_state", 32'(dut.state), 32'd3);
      reset = 1'b0;
      @(negedge clk);
      checkResetState("rst_search");
      reset = 1'b1;

      // Reset asserted during a stalled init refill while a byte is offered.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("mid_refill_in_ready", {31'd0, in_ready}, 32'd1);
      reset    = 1'b0;
      in_valid = 1'b1;
      in_byte  = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      checkResetState("rst_refill");
      reset = 1'b1;
      @(negedge clk);

      checkOutput("ready_exclusive", 32'(excl_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
